// File: rtl/aes_encrypt_arbiter.sv
// Round-robin front end that shares one combinational AES-128 core among NUM_REQ requesters.
// Operands are registered in front of the core, held for a settle window, then the result is captured.
module aes_encrypt_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_plaintext,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_ciphertext,
    output logic                   busy
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // State byte i sits at bits [127-8i -: 8]; bytes are column-major (i = row + 4*col).
    function automatic logic [127:0] enc_round(input logic [127:0] blk, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            s[i] = sbox(blk[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[r+4*c] = s[r+4*((c+r)%4)];
            end
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) begin
            res[127-8*i -: 8] = t[i];
        end
        return res ^ rk;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] st, rk;
        logic [7:0]   rc;
        rk = key;
        st = pt ^ key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = next_key(rk, rc);
            st = enc_round(st, rk, r == 10);
            rc = xtime(rc);
        end
        return st;
    endfunction

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     pt_q, pt_d, key_q, key_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [127:0]     rsp_ct_q, rsp_ct_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic [127:0]     core_out;

    // Multicycle path: pt_q/key_q only change on handshake edges.
    assign core_out = aes_encrypt(pt_q, key_q);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        pt_d     = pt_q;
        key_d    = key_q;
        id_d     = id_q;
        rsp_ct_d = rsp_ct_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    pt_d    = req_plaintext[int'(grant_idx)*128 +: 128];
                    key_d   = req_key[int'(grant_idx)*128 +: 128];
                    id_d    = grant_idx;
                    ptr_d   = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_ct_d = core_out;
                    rsp_id_d = id_q;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            pt_q     <= '0;
            key_q    <= '0;
            id_q     <= '0;
            rsp_ct_q <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            pt_q     <= pt_d;
            key_q    <= key_d;
            id_q     <= id_d;
            rsp_ct_q <= rsp_ct_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign rsp_valid      = (state_q == StResp);
    assign busy           = (state_q != StIdle);
    assign rsp_id         = rsp_id_q;
    assign rsp_ciphertext = rsp_ct_q;

endmodule

// File: tb/tb_aes_encrypt_arbiter.sv
// Randomized bench for aes_encrypt_arbiter: a transaction-level AES/arbitration model is
// compared against the DUT on every falling edge, plus directed FIPS-197 and corner scenarios.
module tb_aes_encrypt_arbiter;

    localparam int N   = 4;
    localparam int S   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*128-1:0] req_plaintext = '0;
    logic [N*128-1:0] req_key = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [127:0]     rsp_ciphertext;
    logic             busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    aes_encrypt_arbiter #(
        .NUM_REQ      (N),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_plaintext (req_plaintext),
        .req_key       (req_key),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_ciphertext(rsp_ciphertext),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference AES built from GF(2^8) arithmetic ----------------
    logic [7:0] m_sbox [256];
    logic [7:0] inv_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] model_aes(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   st [16];
        logic [7:0]   k [16];
        logic [7:0]   tmp [16];
        logic [7:0]   t [4];
        logic [7:0]   rc, acc;
        logic [127:0] res;
        int           coef [4];
        coef = '{2, 3, 1, 1};
        rc   = 8'h01;
        res  = '0;
        for (int i = 0; i < 16; i++) begin
            k[i]  = key[127-8*i -: 8];
            st[i] = pt[127-8*i -: 8] ^ k[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t[0] = m_sbox[k[13]] ^ rc;
            t[1] = m_sbox[k[14]];
            t[2] = m_sbox[k[15]];
            t[3] = m_sbox[k[12]];
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ t[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) st[i] = m_sbox[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd == 10) begin
                        acc = tmp[4*c+r];
                    end else begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++)
                            acc = acc ^ gmul(tmp[4*c+j], 8'(coef[(j-r+4)%4]));
                    end
                    st[4*c+r] = acc ^ k[4*c+r];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- arbitration / timing model ----------------
    function automatic int winner(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = v >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    int           m_phase = 0;  // 0 idle, 1 computing, 2 response offered
    int           m_ptr = 0;
    int           m_due = 0;
    int           m_id = 0;
    int           m_rsp_id = 0;
    int           m_win;
    logic [127:0] m_ct = '0;
    logic [127:0] m_rsp_ct = '0;

    assign m_win = winner(req_valid, m_ptr);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_ptr    <= 0;
            m_rsp_ct <= '0;
            m_rsp_id <= 0;
        end else begin
            case (m_phase)
                0: if (m_win >= 0) begin
                    m_ct    <= model_aes(req_plaintext[m_win*128 +: 128], req_key[m_win*128 +: 128]);
                    m_id    <= m_win;
                    m_ptr   <= (m_win + 1) % N;
                    m_due   <= cyc + S;
                    m_phase <= 1;
                end
                1: if (cyc == m_due) begin
                    m_rsp_ct <= m_ct;
                    m_rsp_id <= m_id;
                    m_phase  <= 2;
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("req_ready", 128'(req_ready),
              (m_phase == 0 && m_win >= 0) ? 128'(N'(1) << m_win) : 128'(0));
        check("rsp_valid", 128'(rsp_valid), 128'(m_phase == 2));
        check("busy", 128'(busy), 128'(m_phase != 0));
        check("rsp_id", 128'(rsp_id), 128'(m_rsp_id));
        check("rsp_ciphertext", rsp_ciphertext, m_rsp_ct);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_slot(input int i, input logic [127:0] pt, input logic [127:0] key);
        req_plaintext[i*128 +: 128] = pt;
        req_key[i*128 +: 128]       = key;
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < N; i++) set_slot(i, rand128(), rand128());
    endtask

    // Returns just after the posedge on which requester i was granted.
    task automatic wait_grant(input int i, output int gc);
        gc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) begin
                @(posedge clk);
                #1;
                gc = cyc;
                check("grant_seen", 128'(1), 128'(1));
                return;
            end
        end
        check("grant_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (!busy) return;
        end
        check("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic run_op(input int id, input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp_ct);
        int gc, n;
        set_slot(id, pt, key);
        req_valid = N'(1) << id;
        rsp_ready = 1'b1;
        wait_grant(id, gc);
        req_valid = '0;
        n = 0;
        while (n < 20 && !rsp_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("vec_latency", 128'(n), 128'(S));
        check("vec_ct", rsp_ciphertext, exp_ct);
        check("vec_id", 128'(rsp_id), 128'(id));
        wait_idle();
    endtask

    initial begin
        logic [127:0]   spt, skey, hold_ct;
        logic [IDW-1:0] hold_id;
        int             gids [5];
        int             gcycs [5];
        int             ng, gc, c0, n;

        for (int x = 0; x < 256; x++) begin
            inv_t = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv_t = 8'(y);
            m_sbox[x] = inv_t ^ rotl8(inv_t, 1) ^ rotl8(inv_t, 2) ^ rotl8(inv_t, 3)
                        ^ rotl8(inv_t, 4) ^ 8'h63;
        end
        check("model_sbox_00", 128'(m_sbox[0]), 128'(8'h63));
        check("model_sbox_53", 128'(m_sbox[8'h53]), 128'(8'hed));
        check("model_fips_b",
              model_aes(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c),
              128'h3925841d02dc09fbdc118597196a0b32);
        check("model_fips_c1",
              model_aes(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f),
              128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32);
        run_op(3, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Round-robin with everybody asking and the consumer always ready.
        randomize_slots();
        req_valid = '1;
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 80 && ng < 5; c++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) begin
                gids[ng]  = $clog2(req_ready);
                gcycs[ng] = cyc;
                ng++;
            end
            #1;
            randomize_slots();
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        check("rr_count", 128'(ng), 128'(5));
        for (int k = 0; k < 5 && k < ng; k++) check("rr_order", 128'(gids[k]), 128'(k % N));
        for (int k = 1; k < ng; k++) check("rr_spacing", 128'(gcycs[k] - gcycs[k-1]), 128'(S + 2));
        wait_idle();

        // Backpressure; operands of the granted requester change right after the handshake.
        rsp_ready = 1'b0;
        spt  = rand128();
        skey = rand128();
        set_slot(1, spt, skey);
        req_valid = 4'b0010;
        wait_grant(1, gc);
        req_valid = 4'b0100;
        set_slot(1, rand128(), rand128());
        n = 0;
        while (n < 20 && !rsp_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        hold_ct = rsp_ciphertext;
        hold_id = rsp_id;
        check("bp_ct", hold_ct, model_aes(spt, skey));
        check("bp_id", 128'(hold_id), 128'(1));
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_valid", 128'(rsp_valid), 128'(1));
            check("bp_ct_stable", rsp_ciphertext, hold_ct);
            check("bp_id_stable", 128'(rsp_id), 128'(hold_id));
            check("bp_no_grant", 128'(req_ready), 128'(0));
        end
        rsp_ready = 1'b1;
        c0 = cyc;
        wait_grant(2, gc);
        check("bp_grant_after_accept", 128'(gc), 128'(c0 + 2));
        req_valid = '0;
        wait_idle();

        // Reset two cycles into SETTLE; requester 1 wins by wrapping from pointer 3.
        req_valid = 4'b0010;
        wait_grant(1, gc);
        req_valid = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ct", rsp_ciphertext, 128'(0));
        check("rst_id", 128'(rsp_id), 128'(0));
        check("rst_ready", 128'(req_ready), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("rst_no_rsp", 128'(rsp_valid), 128'(0));
        end
        req_valid = '1;
        @(negedge clk);
        check("rst_ptr_zero", 128'(req_ready), 128'(4'b0001));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        // Sparse: requester 2 alone, then again from pointer 3 via wrap-around.
        req_valid = 4'b0100;
        wait_grant(2, gc);
        req_valid = '0;
        wait_idle();
        req_valid = 4'b0100;
        @(negedge clk);
        check("sparse_wrap", 128'(req_ready), 128'(4'b0100));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
        req_valid = 4'b1001;
        @(negedge clk);
        check("sparse_ptr3", 128'(req_ready), 128'(4'b1000));
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        // Random traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            randomize_slots();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
